// File: rtl/mips_multicycle_ctrl_if.sv
// Memory bus handshake between the multicycle controller and the bus.
// master: mem_read/mem_write out, mem_waitrequest in.
interface mips_multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic mem_waitrequest;

  modport master (
    output mem_read,
    output mem_write,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    output mem_waitrequest
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: fetch/decode/exec/muldiv/mem/wb, halts on JR $0.
// Ports: clk, rst_n, bus (memory handshake), instruction, jump_target_zero,
// ir_write, pc_write, reg_write_en, hilo_write_en, fetch_phase, active,
// illegal, retired. Optional macro TRAP_ILLEGAL_EN traps unknown opcodes.
module mips_multicycle_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 32,
  parameter int CYC_W         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_multicycle_ctrl_if.master bus,
  input  logic [31:0]           instruction,
  input  logic                  jump_target_zero,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write_en,
  output logic                  hilo_write_en,
  output logic                  fetch_phase,
  output logic                  active,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC,
    MULDIV, MEM, WB, HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_BR, C_WB, C_LOAD, C_STORE,
    C_MULDIV, C_HILO, C_HALT, C_ILL
  } cls_t;

  localparam logic [CYC_W-1:0] CYC_INIT =
    (MULDIV_CYCLES > 0) ?
    CYC_W'(MULDIV_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       unused_bits;

  assign op = instruction[31:26];
  assign fn = instruction[5:0];
  assign rt = instruction[20:16];
  assign unused_bits = ^{instruction[25:21],
                         instruction[15:6]};

  logic op_special, op_regimm, op_jump;
  logic op_jal, op_branch, op_alui;
  logic op_load, op_store;

  assign op_special = (op == 6'b000000);
  assign op_regimm  = (op == 6'b000001);
  assign op_jump    = (op == 6'b000010);
  assign op_jal     = (op == 6'b000011);
  assign op_branch  = op inside {[6'b000100:6'b000111]};
  assign op_alui    = op inside {[6'b001000:6'b001111]};
  assign op_load    = op inside {[6'b100000:6'b100110]};
  assign op_store   = op inside {6'b101000, 6'b101001,
                                 6'b101011};

  cls_t sp_cls, ri_cls, cls;

  always_comb begin
    sp_cls = C_ILL;
    case (fn) inside
      [6'b011000:6'b011011]:
        sp_cls = C_MULDIV;
      6'b010001, 6'b010011:
        sp_cls = C_HILO;
      6'b001000:
        sp_cls = jump_target_zero ? C_HALT : C_BR;
      6'b001001, 6'b000000, 6'b000010,
      6'b000011, 6'b000100, 6'b000110,
      6'b000111, 6'b010000, 6'b010010,
      [6'b100000:6'b100111],
      6'b101010, 6'b101011:
        sp_cls = C_WB;
      default:
        sp_cls = C_ILL;
    endcase
  end

  // Link variants of REGIMM branches write $ra, plain ones do not.
  always_comb begin
    ri_cls = C_ILL;
    case (rt)
      5'b00000, 5'b00001: ri_cls = C_BR;
      5'b10000, 5'b10001: ri_cls = C_WB;
      default:            ri_cls = C_ILL;
    endcase
  end

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      op_special: cls = sp_cls;
      op_regimm:  cls = ri_cls;
      op_jump:    cls = C_BR;
      op_branch:  cls = C_BR;
      op_jal:     cls = C_WB;
      op_alui:    cls = C_WB;
      op_load:    cls = C_LOAD;
      op_store:   cls = C_STORE;
      default:    cls = C_ILL;
    endcase
  end

`ifdef TRAP_ILLEGAL_EN
  logic trap;
`endif

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write_en  = 1'b0;
    hilo_write_en = 1'b0;
    fetch_phase   = 1'b0;
    active        = 1'b1;
`ifdef TRAP_ILLEGAL_EN
    trap          = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        active  = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        fetch_phase  = 1'b1;
        if (!bus.mem_waitrequest) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        unique case (cls)
          C_LOAD, C_STORE: state_d = MEM;
          C_WB:            state_d = WB;
          C_MULDIV: begin
            if (MULDIV_CYCLES > 0) begin
              state_d = MULDIV;
              cyc_d   = CYC_INIT;
            end else begin
              hilo_write_en = 1'b1;
              pc_write      = 1'b1;
              state_d       = FETCH;
            end
          end
          C_HILO: begin
            hilo_write_en = 1'b1;
            pc_write      = 1'b1;
            state_d       = FETCH;
          end
          C_HALT: begin
            pc_write = 1'b1;
            state_d  = HALTED;
          end
          C_ILL: begin
`ifdef TRAP_ILLEGAL_EN
            trap    = 1'b1;
            state_d = HALTED;
`else
            pc_write = 1'b1;
            state_d  = FETCH;
`endif
          end
          C_BR: begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MULDIV: begin
        if (cyc_q == '0) begin
          hilo_write_en = 1'b1;
          pc_write      = 1'b1;
          state_d       = FETCH;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      MEM: begin
        if (cls == C_STORE) begin
          bus.mem_write = 1'b1;
        end else begin
          bus.mem_read = 1'b1;
        end
        if (!bus.mem_waitrequest) begin
          if (cls == C_STORE) begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_d      = FETCH;
      end
      HALTED: active = 1'b0;
      default: begin
        active  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      if (pc_write) begin
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign retired = ret_q;

`ifdef TRAP_ILLEGAL_EN
  logic ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else if (trap) begin
      ill_q <= 1'b1;
    end
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
